// File: rtl/md_pkg.sv
// Shared op encodings and defaults for the E-stage multiply/divide unit.
package md_pkg;
  localparam int MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

  localparam int MD_MULT_CYC = 5;
  localparam int MD_DIV_CYC  = 10;
endpackage

// File: rtl/md_counter.sv
// Load-and-count-down timer for multi-cycle E-stage ops; done flags the cycle whose edge takes cnt 1->0.
// Latency: active for exactly load_val cycles after the load edge. No backpressure; load ignored while active by callers.
module md_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         active,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign active = (cnt != '0);
  assign done   = (cnt == W'(1));
endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/DIV unit holding HI/LO; result commits when the busy window closes.
// Latency: MULT_CYC or DIV_CYC busy cycles, HI/LO visible the cycle after. Backpressure: stall while busy and D needs HI/LO.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYC = MD_MULT_CYC,
  parameter int DIV_CYC  = MD_DIV_CYC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MD_OP_W-1:0]  op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  input  logic                md_use_d,
  output logic [31:0]         hi,
  output logic [31:0]         lo,
  output logic                busy,
  output logic                stall
);
  localparam int CNT_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic        is_long, is_div, cnt_done;
  logic [CW-1:0] load_val;
  logic [31:0] tmp_hi, tmp_lo;
  logic        tmp_wr;

  logic [63:0] prod_s, prod_u, res;
  logic        neg_a, neg_b;
  logic [31:0] ua, ub, ub_nz, uq, ur, q, r;

  assign is_div   = (op == MD_DIV) || (op == MD_DIVU);
  assign is_long  = start && !busy && (op <= MD_DIVU);
  assign load_val = is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);

  md_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (is_long),
    .load_val (load_val),
    .active   (busy),
    .done     (cnt_done)
  );

  // Signed divide runs on magnitudes; this also yields 0x80000000/-1 = 0x80000000 rem 0.
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    neg_a  = (op == MD_DIV) && a[31];
    neg_b  = (op == MD_DIV) && b[31];
    ua     = neg_a ? -a : a;
    ub     = neg_b ? -b : b;
    ub_nz  = (ub == 32'd0) ? 32'd1 : ub;
    uq     = ua / ub_nz;
    ur     = ua % ub_nz;
    q      = (neg_a ^ neg_b) ? -uq : uq;
    r      = neg_a ? -ur : ur;
    res    = 64'd0;
    case (op)
      MD_MULT:          res = prod_s;
      MD_MULTU:         res = prod_u;
      MD_DIV, MD_DIVU:  res = {r, q};
      default:          res = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi     <= 32'd0;
      lo     <= 32'd0;
      tmp_hi <= 32'd0;
      tmp_lo <= 32'd0;
      tmp_wr <= 1'b0;
    end else begin
      if (is_long) begin
        tmp_hi <= res[63:32];
        tmp_lo <= res[31:0];
        tmp_wr <= !(is_div && (b == 32'd0));
      end
      if (cnt_done && tmp_wr) begin
        hi <= tmp_hi;
        lo <= tmp_lo;
      end
      if (start && !busy && op == MD_MTHI) hi <= a;
      if (start && !busy && op == MD_MTLO) lo <= a;
    end
  end

  assign stall = ((start && (op <= MD_DIVU)) || busy) && md_use_d;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboarded bench for mul_div_unit: expected HI/LO queued at issue, checked when busy drops.
module tb_mul_div_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        md_use_d = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, stall;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  mul_div_unit #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .md_use_d(md_use_d), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (!(start === 1'b1 && busy === 1'b1 && op <= 3'd3))
      else $error("illegal start while busy");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    longint sa, sbv, sq, sr;
    longint unsigned pu;
    e.hi = model_hi;
    e.lo = model_lo;
    sa  = longint'($signed(av));
    sbv = longint'($signed(bv));
    case (o)
      3'd0: begin sq = sa * sbv; e.hi = sq[63:32]; e.lo = sq[31:0]; end
      3'd1: begin pu = {32'd0, av} * {32'd0, bv}; e.hi = pu[63:32]; e.lo = pu[31:0]; end
      3'd2: if (bv != 0) begin sq = sa / sbv; sr = sa % sbv; e.hi = sr[31:0]; e.lo = sq[31:0]; end
      3'd3: if (bv != 0) begin e.hi = av % bv; e.lo = av / bv; end
      default: ;
    endcase
    return e;
  endfunction

  // Issue a long op, track busy/stall through the window, then score HI/LO.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic ud, input int n_exp);
    exp_t e;
    int n;
    e = model(o, av, bv);
    sb.push_back(e);
    md_use_d = ud; start = 1'b1; op = o; a = av; b = bv;
    #1;
    tests++;
    if (stall !== ud) begin fails++; $display("FAIL %s stall_start got %b want %b", name, stall, ud); end
    step();
    start = 1'b0; op = 3'd7;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tests++;
      if (stall !== ud) begin fails++; $display("FAIL %s stall_busy cyc %0d got %b want %b", name, n, stall, ud); end
      n++;
      step();
    end
    tests++;
    if (n !== n_exp) begin fails++; $display("FAIL %s busy_cycles got %0d want %0d", name, n, n_exp); end
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL %s stall_after got %b want 0", name, stall); end
    if (sb.size() == 0) begin
      tests++; fails++; $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      tests++;
      if (hi !== e.hi) begin fails++; $display("FAIL %s hi got %h want %h", name, hi, e.hi); end
      tests++;
      if (lo !== e.lo) begin fails++; $display("FAIL %s lo got %h want %h", name, lo, e.lo); end
      model_hi = e.hi; model_lo = e.lo;
    end
    md_use_d = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    tests++;
    if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL reset hilo got %h want 0", {hi, lo}); end
    tests++;
    if ({busy, stall} !== 2'b00) begin fails++; $display("FAIL reset busy_stall got %b want 00", {busy, stall}); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_mult();
    run_op("mult_neg", MD_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, 5);
    tests++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin fails++; $display("FAIL mult_const got %h want FFFFFFFFFFFFFFEB", {hi, lo}); end
    run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 5);
    tests++;
    if ({hi, lo} !== 64'h00000001_FFFFFFFE) begin fails++; $display("FAIL multu_const got %h want 00000001FFFFFFFE", {hi, lo}); end
    run_op("mult_big", MD_MULT, 32'h80000000, 32'h80000000, 1'b0, 5);
  endtask

  task automatic test_div();
    run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 10);
    tests++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin fails++; $display("FAIL div_const got %h want FFFFFFFFFFFFFFFD", {hi, lo}); end
    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10);
    tests++;
    if ({hi, lo} !== 64'h00000000_80000000) begin fails++; $display("FAIL div_ovf_const got %h want 0000000080000000", {hi, lo}); end
    run_op("div_mixed", MD_DIV, 32'd100, 32'hFFFFFFF9, 1'b0, 10);
    run_op("divu", MD_DIVU, 32'hFFFFFFF0, 32'd7, 1'b0, 10);
  endtask

  task automatic test_mthi_mtlo(input logic [31:0] vh, input logic [31:0] vl);
    start = 1'b1; op = MD_MTHI; a = vh;
    step();
    op = MD_MTLO; a = vl;
    step();
    start = 1'b0; op = 3'd7;
    model_hi = vh; model_lo = vl;
    tests++;
    if ({hi, lo} !== {vh, vl}) begin fails++; $display("FAIL mthi_mtlo got %h want %h", {hi, lo}, {vh, vl}); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL mt_busy got %b want 0", busy); end
  endtask

  task automatic test_div_zero();
    test_mthi_mtlo(32'h11, 32'h22);
    run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, 1'b0, 10);
    tests++;
    if ({hi, lo} !== {32'h11, 32'h22}) begin fails++; $display("FAIL divu_zero_const got %h want 0000001100000022", {hi, lo}); end
    run_op("div_zero", MD_DIV, 32'hFFFFFFFF, 32'd0, 1'b0, 10);
  endtask

  task automatic test_nop();
    start = 1'b1; op = 3'd6; a = 32'hDEADBEEF; md_use_d = 1'b1;
    #1;
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL nop_stall got %b want 0", stall); end
    step();
    op = 3'd7;
    step();
    start = 1'b0; md_use_d = 1'b0;
    tests++;
    if ({hi, lo, busy} !== {model_hi, model_lo, 1'b0}) begin
      fails++; $display("FAIL nop_state got %h want %h", {hi, lo, busy}, {model_hi, model_lo, 1'b0});
    end
  endtask

  task automatic test_stall();
    run_op("div_stall", MD_DIV, 32'd1000, 32'd7, 1'b1, 10);
    tests++;
    if (lo !== 32'd142) begin fails++; $display("FAIL mflo_quotient got %h want %h", lo, 32'd142); end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mult", MD_MULTU, 32'h12345678, 32'h9ABCDEF0, 1'b1, 5);
    run_op("b2b_div", MD_DIVU, 32'h12345678, 32'h00001000, 1'b1, 10);
    run_op("b2b_mult2", MD_MULT, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 5);
  endtask

  task automatic test_reset_abort();
    md_use_d = 1'b1; start = 1'b1; op = MD_MULT; a = 32'd1234; b = 32'd5678;
    step();
    start = 1'b0; op = 3'd7;
    step(); step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    tests++;
    if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL abort_hilo got %h want 0", {hi, lo}); end
    tests++;
    if ({busy, stall} !== 2'b00) begin fails++; $display("FAIL abort_busy_stall got %b want 00", {busy, stall}); end
    md_use_d = 1'b0;
    model_hi = 32'd0; model_lo = 32'd0;
    for (int i = 0; i < 8; i++) step();
    tests++;
    if ({hi, lo, busy} !== 65'd0) begin fails++; $display("FAIL abort_late_write got %h want 0", {hi, lo, busy}); end
  endtask

  initial begin
    step();
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_nop();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    test_mult();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline. Holds the architectural HI/LO registers.
- Produces the stall request that the pipeline registers consume. A stall freezes PC and F/D and clears D/E to a bubble.
- It is the stall source for the pipeline-register stall inputs. It must never deadlock and must never drop an operation.

Parameters:
- MULT_CYC, 5, busy cycles for MULT/MULTU (min 1)
- DIV_CYC, 10, busy cycles for DIV/DIVU (min 1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-low (reset==0 resets on the rising edge of clk)
- start  in  1  valid md op in E this cycle; pulse; already gated by stall upstream
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op
- a  in  32  rs operand (forwarded)
- b  in  32  rt operand (forwarded)
- md_use_d  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  long op in progress
- stall  out  1  (start & op<=3 | busy) & md_use_d; combinational

Behaviour:
- Reset (reset==0 at the edge): hi=0, lo=0, busy=0, counter=0, result temporaries=0.
  - Reset wins over start and aborts any in-flight op. No HI/LO write occurs.
- Idle, start=1, op in 0..3 at edge k:
  - Latch a and b. Compute the result into internal tmp_hi/tmp_lo (single-cycle combinational arithmetic is permitted).
  - busy<=1, cnt<=N, where N=MULT_CYC or DIV_CYC.
- While busy: cnt decrements each edge. At the edge where cnt==1: hi<=tmp_hi, lo<=tmp_lo, busy<=0.
  - busy is high for exactly N cycles (cycles k+1..k+N).
  - The new HI/LO value is visible from cycle k+N+1.
- start=1, op=4/5 while idle: hi<=a (MTHI) or lo<=a (MTLO) at the same edge. busy stays 0.
- start=1 while busy: illegal because the stall prevents it. The bench asserts it never occurs. RTL ignores it (no latch, counter unaffected).
- op 6/7 with start=1: no state change.
- MULT: signed 32x32 -> 64; hi = upper word, lo = lower word. MULTU: unsigned.
- DIV: signed. lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU: unsigned.
- Divide by zero (b==0): busy runs the full DIV_CYC, but hi/lo stay unchanged at completion.
- stall is a pure function of the current cycle's inputs and state.
  - It asserts in the start cycle itself if D holds an md instruction, so a back-to-back mfhi is held.
  - It deasserts in the cycle after busy falls.
- hi/lo outputs are register outputs. Reads (mfhi/mflo) in E use them directly; there is no forwarding inside this unit.

Decomposition:
- Shared package md_pkg:
  - op encodings MD_MULT..MD_MTLO
  - default cycle constants MD_MULT_CYC=5, MD_DIV_CYC=10
  - 3-bit op width
- One natural sub-module: md_counter (load value, decrement, done pulse at 1->0 transition), reusable for any future multi-cycle E-stage op.
- The arithmetic stays inline.

Test Plan:
- MULT a=0xFFFFFFFD(-3), b=7 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9(-7), b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=0 with hi/lo preset via MTHI 0x11/MTLO 0x22 -> busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
- DIV start with md_use_d=1 (mflo in D) -> stall=1 from the start cycle through the last busy cycle (11 cycles total), 0 on the next cycle; the mflo then reads the quotient.
- MULT started, reset=0 pulsed at busy cycle 3 -> next cycle hi=lo=0, busy=0, stall=0; later idle cycles show no delayed write.
